uart_tx_arb: RTL and testbench



---
 rtl/uart_tx_arb.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares the UART transmit FIFO write port among NREQ byte
// requesters. Arbitration is round-robin. A requester keeps the port until it
// sends a byte flagged last, or until it has been idle for TMO cycles.
module uart_tx_arb #(
   parameter int unsigned NREQ = 3,
   parameter int unsigned TMO  = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   output logic [7:0]        tx_wdata,
   output logic              tx_wten,
   input  logic              tx_fifo_full,
   input  logic              tx_fifo_overrun,
   output logic              gnt_valid,
   output logic [2:0]        gnt_id,
   output logic              tmo_pulse,
   output logic              err_overrun
);

   typedef enum logic {ARB, LOCK} state_t;

   state_t      state, state_nxt;
   logic [2:0]  gnt_id_nxt;
   logic [2:0]  rr_ptr, rr_ptr_nxt;
   logic [2:0]  ptr_after_owner;
   logic [15:0] idle_cnt, idle_cnt_nxt;

   logic        owner_valid;
   logic        owner_last;
   logic [7:0]  owner_data;

   logic        pick_found;
   logic [2:0]  pick_id;

   logic        accept;
   logic        timeout;

   // Owner-side view: valid/last/data of the requester selected by gnt_id.
   always_comb begin
      owner_valid = 1'b0;
      owner_last  = 1'b0;
      owner_data  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt_id == 3'(i)) begin
            owner_valid = req_valid[i];
            owner_last  = req_last[i];
            owner_data  = req_data[8*i +: 8];
         end
      end
   end

   // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
   always_comb begin : rr_pick
      int unsigned idx;
      pick_found = 1'b0;
      pick_id    = '0;
      idx        = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = 32'(rr_ptr) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!pick_found && req_valid[idx]) begin
            pick_found = 1'b1;
            pick_id    = 3'(idx);
         end
      end
   end

   // Pointer to the requester after the current owner, used on any release.
   always_comb begin
      ptr_after_owner = (gnt_id == 3'(NREQ - 1)) ? 3'd0 : gnt_id + 3'd1;
   end

   // Next-state, datapath steering and release/timeout decisions.
   always_comb begin
      state_nxt    = state;
      gnt_id_nxt   = gnt_id;
      rr_ptr_nxt   = rr_ptr;
      idle_cnt_nxt = idle_cnt;
      req_ready    = '0;
      tx_wten      = 1'b0;
      tx_wdata     = '0;
      tmo_pulse    = 1'b0;
      gnt_valid    = 1'b0;
      accept       = 1'b0;
      timeout      = 1'b0;

      case (state)
         ARB: begin
            if (pick_found) begin
               gnt_id_nxt   = pick_id;
               idle_cnt_nxt = '0;
               state_nxt    = LOCK;
            end
         end

         LOCK: begin
            gnt_valid = 1'b1;
            for (int unsigned i = 0; i < NREQ; i++) begin
               if (gnt_id == 3'(i)) begin
                  req_ready[i] = ~tx_fifo_full;
               end
            end
            accept  = owner_valid & ~tx_fifo_full;
            tx_wten = accept;
            if (accept) begin
               tx_wdata = owner_data;
            end

            // Timeout fires on the idle cycle that brings the count to TMO;
            // an accepted byte always has valid high, so it can never coincide.
            timeout = ~owner_valid && (idle_cnt >= 16'(TMO - 1));

            if (accept) begin
               idle_cnt_nxt = '0;
               if (owner_last) begin
                  state_nxt  = ARB;
                  rr_ptr_nxt = ptr_after_owner;
               end
            end else if (!owner_valid) begin
               if (idle_cnt != '1) begin
                  idle_cnt_nxt = idle_cnt + 16'd1;
               end
               if (timeout) begin
                  tmo_pulse  = 1'b1;
                  state_nxt  = ARB;
                  rr_ptr_nxt = ptr_after_owner;
               end
            end
         end

         default: begin
            state_nxt = ARB;
         end
      endcase
   end

   // State, grant, round-robin pointer and idle counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ARB;
         gnt_id   <= '0;
         rr_ptr   <= '0;
         idle_cnt <= '0;
      end else begin
         state    <= state_nxt;
         gnt_id   <= gnt_id_nxt;
         rr_ptr   <= rr_ptr_nxt;
         idle_cnt <= idle_cnt_nxt;
      end
   end

   // Sticky overrun flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_overrun <= 1'b0;
      end else if (tx_fifo_overrun) begin
         err_overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed test-plan scenarios plus randomized traffic, all
// checked every cycle against a behavioural model of the arbiter.
module tb_uart_tx_arb;

   localparam int unsigned NREQ = 3;
   localparam int unsigned TMO  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic [7:0]        tx_wdata;
   logic              tx_wten;
   logic              tx_fifo_full;
   logic              tx_fifo_overrun;
   logic              gnt_valid;
   logic [2:0]        gnt_id;
   logic              tmo_pulse;
   logic              err_overrun;

   always #5 clk = ~clk;

   uart_tx_arb #(.NREQ(NREQ), .TMO(TMO)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_data        (req_data),
      .req_last        (req_last),
      .req_ready       (req_ready),
      .tx_wdata        (tx_wdata),
      .tx_wten         (tx_wten),
      .tx_fifo_full    (tx_fifo_full),
      .tx_fifo_overrun (tx_fifo_overrun),
      .gnt_valid       (gnt_valid),
      .gnt_id          (gnt_id),
      .tmo_pulse       (tmo_pulse),
      .err_overrun     (err_overrun)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: owner index (-1 when nobody owns), last owner, rr pointer,
   // consecutive idle cycles of the owner, sticky overrun.
   int              m_owner, m_last, m_rr, m_idle;
   bit              m_err;
   logic [NREQ-1:0] m_acc;

   logic            s_wten, s_gv, s_tmo, s_err;
   logic [7:0]      s_wdata;
   logic [2:0]      s_gid;
   logic [NREQ-1:0] s_ready;

   task automatic model_reset();
      m_owner = -1;
      m_last  = 0;
      m_rr    = 0;
      m_idle  = 0;
      m_err   = 1'b0;
      m_acc   = '0;
   endtask

   // One clock cycle: compare at negedge, then advance the model past posedge.
   task automatic step();
      logic [NREQ-1:0] e_ready;
      logic            e_wten, e_tmo, e_gv;
      logic [7:0]      e_wdata;
      logic [2:0]      e_gid;
      int              o, j;
      bit              found;
      @(negedge clk);
      e_ready = '0;
      e_wten  = 1'b0;
      e_tmo   = 1'b0;
      e_gv    = 1'b0;
      e_wdata = '0;
      e_gid   = 3'(m_last);
      o       = m_owner;
      if (o >= 0) begin
         e_gv  = 1'b1;
         e_gid = 3'(o);
         if (!tx_fifo_full) e_ready[o] = 1'b1;
         e_wten = req_valid[o] && !tx_fifo_full;
         if (e_wten) e_wdata = req_data[8*o +: 8];
         e_tmo = !req_valid[o] && (m_idle + 1 >= int'(TMO));
      end
      s_wten = tx_wten; s_gv = gnt_valid; s_tmo = tmo_pulse; s_err = err_overrun;
      s_wdata = tx_wdata; s_gid = gnt_id; s_ready = req_ready;
      check("req_ready", req_ready, e_ready);
      check("tx_wten", tx_wten, e_wten);
      check("tx_wdata", tx_wdata, e_wdata);
      check("gnt_valid", gnt_valid, e_gv);
      check("gnt_id", gnt_id, e_gid);
      check("tmo_pulse", tmo_pulse, e_tmo);
      check("err_overrun", err_overrun, m_err);
      m_acc = req_valid & e_ready;
      @(posedge clk);
      #1;
      if (o < 0) begin
         found = 1'b0;
         for (int k = 0; k < int'(NREQ); k++) begin
            j = (m_rr + k) % int'(NREQ);
            if (!found && req_valid[j]) begin
               found   = 1'b1;
               m_owner = j;
               m_last  = j;
               m_idle  = 0;
            end
         end
      end else if (e_wten) begin
         m_idle = 0;
         if (req_last[o]) begin
            m_owner = -1;
            m_rr    = (o + 1) % int'(NREQ);
         end
      end else if (!req_valid[o]) begin
         if (m_idle < 65535) m_idle++;
         if (m_idle >= int'(TMO)) begin
            m_owner = -1;
            m_rr    = (o + 1) % int'(NREQ);
         end
      end
      if (tx_fifo_overrun) m_err = 1'b1;
   endtask

   task automatic do_reset();
      req_valid = '0; req_data = '0; req_last = '0;
      tx_fifo_full = 1'b0; tx_fifo_overrun = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_gnt_valid", gnt_valid, 0);
      check("rst_tx_wten", tx_wten, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_gnt_id", gnt_id, 0);
      check("rst_err", err_overrun, 0);
      check("rst_tmo", tmo_pulse, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   int order[4] = '{0, 1, 2, 0};
   int vprob;

   initial begin
      rst_n = 1'b0;
      model_reset();

      // Single requester: three bytes, last on the third.
      do_reset();
      req_valid[0] = 1'b1; req_data[7:0] = 8'h41;
      step(); check("a_arb_gv", s_gv, 0);
      step(); check("a_w41", {s_wten, s_wdata}, 9'h141); check("a_gid", s_gid, 0);
      req_data[7:0] = 8'h42;
      step(); check("a_w42", {s_wten, s_wdata}, 9'h142);
      req_data[7:0] = 8'h43; req_last[0] = 1'b1;
      step(); check("a_w43", {s_wten, s_wdata}, 9'h143);
      req_valid[0] = 1'b0; req_last[0] = 1'b0;
      step(); check("a_rel_gv", s_gv, 0); check("a_gid_hold", s_gid, 0);
      req_valid = 3'b011; req_last = 3'b011;
      step();
      step(); check("a_rr_gid", s_gid, 1);

      // Round-robin with 1-byte packets from all requesters.
      do_reset();
      req_valid = '1; req_last = '1; req_data = {8'h22, 8'h11, 8'h00};
      for (int k = 0; k < 8; k++) begin
         step();
         check($sformatf("b_gv%0d", k), s_gv, k % 2);
         if (k % 2 == 1) check($sformatf("b_gid%0d", k), s_gid, order[k/2]);
      end

      // Packet lock: requester 1 owns, requester 0 waits, requester 2 follows.
      do_reset();
      req_valid = 3'b010; req_data[15:8] = 8'hB0;
      step();
      step(); check("c_own", s_gid, 1); check("c_wB0", {s_wten, s_wdata}, 9'h1B0);
      req_data[15:8] = 8'hB1;
      step();
      req_valid[0] = 1'b1; req_data[7:0] = 8'hA0; req_last[0] = 1'b1;
      req_valid[1] = 1'b0;
      step(); check("c_r0_blk", s_ready[0], 0); check("c_hold_gv", s_gv, 1);
      req_valid[1] = 1'b1; req_data[15:8] = 8'hB2;
      step(); check("c_r0_blk", s_ready[0], 0);
      req_data[15:8] = 8'hB3; req_last[1] = 1'b1; req_valid[2] = 1'b1; req_last[2] = 1'b1;
      step(); check("c_r0_blk", s_ready[0], 0); check("c_wB3", {s_wten, s_wdata}, 9'h1B3);
      req_valid[1] = 1'b0;
      step(); check("c_arb_gv", s_gv, 0);
      step(); check("c_next", s_gid, 2);

      // Full backpressure for 5 cycles, longer than TMO.
      do_reset();
      req_valid = 3'b001; req_data[7:0] = 8'h5A; req_last[0] = 1'b1; tx_fifo_full = 1'b1;
      step();
      for (int k = 0; k < 5; k++) begin
         step();
         check("d_wten", s_wten, 0); check("d_ready", s_ready, 0);
         check("d_tmo", s_tmo, 0); check("d_gv", s_gv, 1);
      end
      tx_fifo_full = 1'b0;
      step(); check("d_w5A", {s_wten, s_wdata}, 9'h15A); check("d_err", s_err, 0);

      // Timeout after 4 owner-idle cycles; pending requester 1 follows.
      do_reset();
      req_valid = 3'b011; req_last = 3'b010; req_data = {8'h00, 8'h99, 8'h77};
      step();
      step(); check("e_w77", {s_wten, s_wdata}, 9'h177);
      req_valid[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(); check($sformatf("e_tmo%0d", k), s_tmo, (k == 3) ? 1 : 0);
      end
      step(); check("e_arb_gv", s_gv, 0);
      step(); check("e_next", s_gid, 1); check("e_next_gv", s_gv, 1);

      // Reset mid-packet drops everything at once.
      do_reset();
      req_valid = 3'b100; req_data[23:16] = 8'hC3;
      step();
      step(); check("f_own", s_gid, 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("f_gv", gnt_valid, 0); check("f_wten", tx_wten, 0);
      check("f_ready", req_ready, 0); check("f_wdata", tx_wdata, 0);
      check("f_gid", gnt_id, 0); check("f_tmo", tmo_pulse, 0);
      req_valid = 3'b110;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      step();
      step(); check("f_first", s_gid, 1);

      // Overrun latches until reset.
      tx_fifo_overrun = 1'b1;
      step();
      tx_fifo_overrun = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(); check("g_err", s_err, 1);
      end
      do_reset();

      // Randomized traffic.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         vprob = ((cyc / 500) % 2 == 1) ? 25 : 80;
         step();
         for (int i = 0; i < int'(NREQ); i++) begin
            if (m_acc[i] || !req_valid[i]) begin
               req_valid[i] = ($urandom_range(0, 99) < vprob);
               req_data[8*i +: 8] = 8'($urandom);
               req_last[i] = ($urandom_range(0, 3) == 0);
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         tx_fifo_full    = ($urandom_range(0, 3) == 0);
         tx_fifo_overrun = ($urandom_range(0, 299) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
